// File: rtl/fetch_unit.sv
// Instruction-fetch front end: one outstanding cache read, PC-tagged circular queue, redirect flush.
// Optional performance counters are compiled in when FETCH_STATS_EN is defined.
module fetch_unit #(
    parameter int          DEPTH    = 16,
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [31:0]                imem_addr,
    output logic [3:0]                 imem_rmask,
    input  logic [31:0]                imem_rdata,
    input  logic                       imem_resp,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    input  logic                       deq_ready,
    output logic                       deq_valid,
    output logic [31:0]                deq_inst,
    output logic [31:0]                deq_pc,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [31:0]                stat_fetched,
    output logic [31:0]                stat_dropped,
    output logic [31:0]                stat_full_stall
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0] FULL = DEPTH[CW:0];

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
    state_t state_q, state_d;

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   pc_mem_q   [DEPTH];

    logic          deq_fire, enq_fire, room, issue;
    logic [CW:0]   occ_next;
    logic [31:0]   pc_inc;

    assign pc_inc    = pc_q + 32'd4;
    assign deq_valid = (count_q != '0);
    assign deq_fire  = deq_valid & deq_ready;
    assign enq_fire  = (state_q == WAIT) & imem_resp & ~redirect_valid;
    // Occupancy after this cycle's traffic; issuing only below DEPTH reserves a slot for the reply.
    assign occ_next  = {1'b0, count_q} + {{CW{1'b0}}, enq_fire} - {{CW{1'b0}}, deq_fire};
    assign room      = (occ_next < FULL);

    assign deq_inst  = inst_mem_q[head_q];
    assign deq_pc    = pc_mem_q[head_q];
    assign count     = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!redirect_valid && room) state_d = WAIT;
            WAIT: begin
                if (redirect_valid)  state_d = imem_resp ? IDLE : DROP;
                else if (imem_resp)  state_d = room ? WAIT : IDLE;
            end
            DROP: if (imem_resp) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue = 1'b0;
        case (state_q)
            IDLE:    issue = ~redirect_valid & room;
            WAIT:    issue = enq_fire & room;
            default: issue = 1'b0;
        endcase
        if (rst) issue = 1'b0;
    end

    assign imem_rmask = issue ? 4'hF : 4'h0;
    // A back-to-back reissue must already point at the next word in the response cycle.
    assign imem_addr  = enq_fire ? pc_inc : pc_q;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) pc_d = redirect_pc;
        else if (enq_fire)  pc_d = pc_inc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (redirect_valid) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (deq_fire) head_q <= head_q + PW'(1);
                if (enq_fire) tail_q <= tail_q + PW'(1);
                count_q <= occ_next[CW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            inst_mem_q[tail_q] <= imem_rdata;
            pc_mem_q[tail_q]   <= pc_q;
        end
    end

`ifdef FETCH_STATS_EN
    logic        drop_resp, full_stall;
    logic [31:0] fetched_q, dropped_q, stall_q;

    assign drop_resp  = imem_resp & ((state_q == DROP) | ((state_q == WAIT) & redirect_valid));
    assign full_stall = (state_q == IDLE) & ~redirect_valid & ~room;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q <= '0;
            dropped_q <= '0;
            stall_q   <= '0;
        end else begin
            if (enq_fire)   fetched_q <= fetched_q + 32'd1;
            if (drop_resp)  dropped_q <= dropped_q + 32'd1;
            if (full_stall) stall_q   <= stall_q + 32'd1;
        end
    end

    assign stat_fetched    = fetched_q;
    assign stat_dropped    = dropped_q;
    assign stat_full_stall = stall_q;
`else
    assign stat_fetched    = '0;
    assign stat_dropped    = '0;
    assign stat_full_stall = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, directed corner sequences and a
// randomized run against a queue-based behavioural model with a variable-latency cache.
module tb_fetch_unit;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h1eceb000;
    localparam int          CW    = $clog2(DEPTH+1);
`ifdef FETCH_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   imem_addr;
    logic [3:0]    imem_rmask;
    logic [31:0]   imem_rdata;
    logic          imem_resp;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          deq_ready;
    logic          deq_valid;
    logic [31:0]   deq_inst;
    logic [31:0]   deq_pc;
    logic [CW-1:0] count;
    logic [31:0]   stat_fetched, stat_dropped, stat_full_stall;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .deq_ready(deq_ready), .deq_valid(deq_valid),
        .deq_inst(deq_inst), .deq_pc(deq_pc), .count(count),
        .stat_fetched(stat_fetched), .stat_dropped(stat_dropped),
        .stat_full_stall(stat_full_stall)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_stat(input logic [31:0] v);
        return STATS_ON ? v : 32'd0;
    endfunction

    // Behavioural model: fetch PC, queue of {inst, pc}, and whether a request is in flight / kept.
    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    bit          m_pend, m_keep;
    logic [31:0] m_fet, m_drp, m_stl;
    // Cache model
    bit          c_busy;
    int          c_cnt, c_lat;
    // Request observation
    int          n_req;
    logic [31:0] first_addr;

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; deq_ready = 1'b0;
        imem_resp = 1'b0; imem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_q.delete(); m_pc = RPC; m_pend = 0; m_keep = 0;
        m_fet = 0; m_drp = 0; m_stl = 0;
        c_busy = 0; c_cnt = 0;
    endtask

    // One clock: drive inputs at negedge, check against the model, advance model at the edge.
    task automatic cyc(input logic rd, input logic [31:0] rpc, input logic rdy);
        logic rsp, enq, deq, iss, dut_req;
        int   occ;
        redirect_valid = rd; redirect_pc = rpc; deq_ready = rdy;
        rsp = c_busy && (c_cnt == 0);
        imem_resp = rsp; imem_rdata = $urandom;
        #1;
        enq = m_pend && m_keep && rsp && !rd;
        deq = (m_q.size() != 0) && rdy;
        occ = m_q.size() + int'(enq) - int'(deq);
        iss = !rd && (occ < DEPTH) && (!m_pend || enq);
        chk("rmask", imem_rmask, iss ? 4'hF : 4'h0);
        chk("addr", imem_addr, enq ? m_pc + 32'd4 : m_pc);
        chk("deq_valid", deq_valid, m_q.size() != 0);
        chk("count", count, m_q.size());
        if (m_q.size() != 0) begin
            chk("deq_inst", deq_inst, m_q[0][63:32]);
            chk("deq_pc", deq_pc, m_q[0][31:0]);
        end
        chk("stat_fetched", stat_fetched, exp_stat(m_fet));
        chk("stat_dropped", stat_dropped, exp_stat(m_drp));
        chk("stat_full_stall", stat_full_stall, exp_stat(m_stl));
        dut_req = (imem_rmask == 4'hF);
        if (dut_req) begin
            if (n_req == 0) first_addr = imem_addr;
            n_req++;
        end
        if (enq) m_fet++;
        if (m_pend && rsp && (!m_keep || rd)) m_drp++;
        if (!m_pend && !rd && occ >= DEPTH) m_stl++;
        if (rd) begin
            m_q.delete();
            m_pc   = rpc;
            m_pend = m_pend && !rsp;
            m_keep = 0;
        end else begin
            if (deq) void'(m_q.pop_front());
            if (enq) begin
                m_q.push_back({imem_rdata, m_pc});
                m_pc = m_pc + 32'd4;
            end
            if (iss) begin
                m_pend = 1; m_keep = 1;
            end else if (rsp) begin
                m_pend = 0;
            end
        end
        if (rsp) c_busy = 0;
        if (dut_req) begin
            c_busy = 1; c_cnt = c_lat - 1;
        end else if (c_busy) begin
            c_cnt--;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        rst, resp, rd, rdy;
        logic [31:0] rdata, rpc;
        logic [3:0]  e_rmask;
        logic [31:0] e_addr;
        logic        e_valid;
        int          e_count;
        logic [31:0] e_pc, e_inst;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rs, input logic [31:0] rdat,
                                input logic rd, input logic [31:0] rpc, input logic rdy,
                                input logic [3:0] em, input logic [31:0] ea, input logic ev,
                                input int ec, input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.rst = r; v.resp = rs; v.rdata = rdat; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
        v.e_rmask = em; v.e_addr = ea; v.e_valid = ev; v.e_count = ec; v.e_pc = ep; v.e_inst = ei;
        return v;
    endfunction

    localparam logic [31:0] I0 = 32'h11110000, I1 = 32'h22220001,
                            I2 = 32'h33330002, I3 = 32'h44440003;
    vec_t tv[11];

    initial begin
        logic [31:0] nxt;
        logic        rd;
        logic [31:0] rpc;

        // Reset, 1-cycle hits, back-to-back fetch, coincident redirect, reset mid-WAIT.
        tv[0]  = mk(1, 0, 0,  0, 0,            0, 4'h0, RPC,          0, 0, 0,            0);
        tv[1]  = mk(0, 0, 0,  0, 0,            0, 4'hF, RPC,          0, 0, 0,            0);
        tv[2]  = mk(0, 1, I0, 0, 0,            0, 4'hF, 32'h1eceb004, 0, 0, 0,            0);
        tv[3]  = mk(0, 1, I1, 0, 0,            0, 4'hF, 32'h1eceb008, 1, 1, RPC,          I0);
        tv[4]  = mk(0, 0, 0,  0, 0,            1, 4'h0, 32'h1eceb008, 1, 2, RPC,          I0);
        tv[5]  = mk(0, 1, I2, 1, 32'h1eceb100, 0, 4'h0, 32'h1eceb008, 1, 1, 32'h1eceb004, I1);
        tv[6]  = mk(0, 0, 0,  0, 0,            0, 4'hF, 32'h1eceb100, 0, 0, 0,            0);
        tv[7]  = mk(0, 1, I3, 0, 0,            0, 4'hF, 32'h1eceb104, 0, 0, 0,            0);
        tv[8]  = mk(0, 0, 0,  0, 0,            0, 4'h0, 32'h1eceb104, 1, 1, 32'h1eceb100, I3);
        tv[9]  = mk(1, 0, 0,  0, 0,            0, 4'h0, 32'h1eceb104, 1, 1, 32'h1eceb100, I3);
        tv[10] = mk(0, 0, 0,  0, 0,            0, 4'hF, RPC,          0, 0, 0,            0);

        c_lat = 1; n_req = 0; first_addr = '0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; deq_ready = 1'b0;
        imem_resp = 1'b0; imem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            rst = tv[i].rst; imem_resp = tv[i].resp; imem_rdata = tv[i].rdata;
            redirect_valid = tv[i].rd; redirect_pc = tv[i].rpc; deq_ready = tv[i].rdy;
            #1;
            chk($sformatf("v%0d rmask", i), imem_rmask, tv[i].e_rmask);
            chk($sformatf("v%0d addr", i), imem_addr, tv[i].e_addr);
            chk($sformatf("v%0d deq_valid", i), deq_valid, tv[i].e_valid);
            chk($sformatf("v%0d count", i), count, tv[i].e_count);
            if (tv[i].e_valid) begin
                chk($sformatf("v%0d deq_pc", i), deq_pc, tv[i].e_pc);
                chk($sformatf("v%0d deq_inst", i), deq_inst, tv[i].e_inst);
            end
            @(negedge clk);
        end

        // Full stall, then a single deq_ready pulse.
        do_reset(); c_lat = 1; n_req = 0;
        repeat (10) cyc(0, 0, 0);
        chk("stall count", count, DEPTH);
        chk("stall requests", n_req, 4);
        n_req = 0;
        cyc(0, 0, 1);
        repeat (6) cyc(0, 0, 0);
        chk("pulse requests", n_req, 1);
        chk("pulse count", count, DEPTH);

        // Redirect on the second cycle of a 5-cycle miss.
        do_reset(); c_lat = 1;
        cyc(0, 0, 0);
        c_lat = 5;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 32'h1eceb100, 0);
        chk("redir flush valid", deq_valid, 1'b0);
        chk("redir flush count", count, 0);
        n_req = 0;
        repeat (6) cyc(0, 0, 0);
        chk("redir next addr", first_addr, 32'h1eceb100);
        chk("redir dropped", stat_dropped, exp_stat(1));

        // Redirect coincident with the response.
        do_reset(); c_lat = 3;
        cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        cyc(1, 32'h1eceb400, 0);
        chk("coinc count", count, 0);
        n_req = 0;
        cyc(0, 0, 0);
        chk("coinc next addr", first_addr, 32'h1eceb400);

        // Two redirects while the dropped response is outstanding.
        do_reset(); c_lat = 5;
        cyc(0, 0, 0);
        cyc(1, 32'h1eceb200, 0);
        cyc(1, 32'h1eceb300, 0);
        repeat (12) cyc(0, 0, 0);
        chk("double redir valid", deq_valid, 1'b1);
        chk("double redir pc", deq_pc, 32'h1eceb300);
        chk("double redir dropped", stat_dropped, exp_stat(1));

        // Steady enqueue+dequeue through pointer wrap: PCs must come out in order.
        do_reset(); c_lat = 1;
        repeat (8) cyc(0, 0, 0);
        nxt = RPC;
        for (int k = 0; k < 40; k++) begin
            if (deq_valid) begin
                chk("wrap order", deq_pc, nxt);
                nxt = nxt + 32'd4;
            end
            cyc(0, 0, 1);
        end

        // 32-bit PC wrap.
        do_reset(); c_lat = 1;
        cyc(1, 32'hFFFFFFF8, 0);
        repeat (8) cyc(0, 0, 1);

        // Randomized run, with one reset in the middle.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) do_reset();
            c_lat = $urandom_range(1, 4);
            rd    = ($urandom_range(0, 99) < 3);
            rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | ({$urandom} & 32'hC))
                                                : ({$urandom} & 32'hFFFFFFFC);
            cyc(rd, rpc, $urandom_range(0, 9) < 7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
